// File: rtl/calc_pkg.sv
// calc_pkg: shared state codes, operator and display-select constants for the
// keypad calculator sequencer and its helpers.
package calc_pkg;

  // Sequencer states, kept as plain 3-bit codes so older blocks can share them.
  typedef logic [2:0] state_t;

  localparam state_t ENTER_V1 = 3'd0;
  localparam state_t OP_WAIT  = 3'd1;
  localparam state_t ENTER_V2 = 3'd2;
  localparam state_t EXEC     = 3'd3;
  localparam state_t SHOW     = 3'd4;
  localparam state_t ERROR    = 3'd5;

  // Operator encodings presented to the arithmetic unit.
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Display source selection.
  localparam logic [1:0] DISP_V1  = 2'd0;
  localparam logic [1:0] DISP_V2  = 2'd1;
  localparam logic [1:0] DISP_ANS = 2'd2;
  localparam logic [1:0] DISP_ERR = 2'd3;

  // Display source for a state; EXEC keeps whatever was shown before.
  function automatic logic [1:0] disp_for_state(input state_t s, input logic [1:0] hold);
    logic [1:0] d;
    d = hold;
    case (s)
      ENTER_V1, OP_WAIT: d = DISP_V1;
      ENTER_V2:          d = DISP_V2;
      SHOW:              d = DISP_ANS;
      ERROR:             d = DISP_ERR;
      default:           d = hold;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/calc_watchdog.sv
// calc_watchdog: saturating cycle counter that flags when the arithmetic unit
// has been busy for ARITH_TIMEOUT cycles without answering.
module calc_watchdog
  import calc_pkg::*;
#(
  parameter int ARITH_TIMEOUT = 32
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(ARITH_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(ARITH_TIMEOUT);

  logic [CW-1:0] r_count;

  // Count enabled cycles, restart on clear, and stick at the limit.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expire = (r_count == LIMIT);

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: turns keypad events into operand-register strobes and an
// arithmetic start/done handshake, with display select and error recovery.
// Optional feature: define CALC_CHAIN_EN to let an operator key typed while
// entering V2 launch the pending operation and chain into the new operator.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int ARITH_TIMEOUT = 32
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_newhex,
  input  logic [3:0] i_hexcode,
  input  logic       i_newop,
  input  logic [1:0] i_opcode,
  input  logic       i_eq,
  input  logic       i_clr,
  input  logic       i_alu_done,
  input  logic       i_alu_ovw,
  output logic [3:0] o_hex_out,
  output logic       o_v1_shift,
  output logic       o_v2_shift,
  output logic       o_v1_clear,
  output logic       o_v2_clear,
  output logic       o_v1_load_ans,
  output logic [1:0] o_alu_op,
  output logic       o_alu_start,
  output logic [1:0] o_disp_sel,
  output logic       o_err
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] DIGITS_MAX = CW'(DIGITS);

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_count, w_count_next;
  logic [3:0]    r_hex_out, w_hex_next;
  logic [1:0]    r_alu_op, w_op_next;
  logic [1:0]    r_disp_sel;
  logic          r_err;
  logic          r_v1_shift, r_v2_shift, r_v1_clear, r_v2_clear, r_v1_load_ans, r_alu_start;
  logic          w_v1_shift, w_v2_shift, w_v1_clear, w_v2_clear, w_v1_load_ans, w_alu_start;
  logic          w_clr, w_eq, w_op, w_hex, w_expire;

`ifdef CALC_CHAIN_EN
  logic          r_chain, w_chain_next;
  logic [1:0]    r_next_op, w_next_op_next;
`endif

  // One key event per cycle wins: clr, then eq, then operator, then digit.
  assign w_clr = i_clr;
  assign w_eq  = i_eq & ~i_clr;
  assign w_op  = i_newop & ~i_eq & ~i_clr;
  assign w_hex = i_newhex & ~i_newop & ~i_eq & ~i_clr;

  calc_watchdog #(.ARITH_TIMEOUT(ARITH_TIMEOUT)) u_watchdog (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_alu_start),
    .i_enable (r_state == EXEC),
    .o_expire (w_expire)
  );

  // Decide the next state, counters and the strobes to register this cycle.
  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_hex_next    = r_hex_out;
    w_op_next     = r_alu_op;
    w_v1_shift    = 1'b0;
    w_v2_shift    = 1'b0;
    w_v1_clear    = 1'b0;
    w_v2_clear    = 1'b0;
    w_v1_load_ans = 1'b0;
    w_alu_start   = 1'b0;
`ifdef CALC_CHAIN_EN
    w_chain_next   = r_chain;
    w_next_op_next = r_next_op;
`endif
    if (w_clr) begin
      w_v1_clear   = 1'b1;
      w_v2_clear   = 1'b1;
      w_count_next = '0;
      w_state_next = ENTER_V1;
    end else begin
      case (r_state)
        ENTER_V1: begin
          if (w_op) begin
            w_op_next    = i_opcode;
            w_count_next = '0;
            w_state_next = OP_WAIT;
          end else if (w_hex && (r_count < DIGITS_MAX)) begin
            w_v1_shift   = 1'b1;
            w_hex_next   = i_hexcode;
            w_count_next = r_count + CW'(1);
          end
        end
        OP_WAIT: begin
          if (w_op) begin
            w_op_next = i_opcode;
          end else if (w_hex) begin
            w_v2_clear   = 1'b1;
            w_v2_shift   = 1'b1;
            w_hex_next   = i_hexcode;
            w_count_next = CW'(1);
            w_state_next = ENTER_V2;
          end
        end
        ENTER_V2: begin
          if (w_eq) begin
            w_alu_start  = 1'b1;
            w_state_next = EXEC;
`ifdef CALC_CHAIN_EN
            w_chain_next = 1'b0;
          end else if (w_op) begin
            w_alu_start    = 1'b1;
            w_next_op_next = i_opcode;
            w_chain_next   = 1'b1;
            w_state_next   = EXEC;
`endif
          end else if (w_hex && (r_count < DIGITS_MAX)) begin
            w_v2_shift   = 1'b1;
            w_hex_next   = i_hexcode;
            w_count_next = r_count + CW'(1);
          end
        end
        EXEC: begin
          if (i_alu_done) begin
            if (i_alu_ovw) begin
              w_state_next = ERROR;
`ifdef CALC_CHAIN_EN
            end else if (r_chain) begin
              w_v1_load_ans = 1'b1;
              w_v2_clear    = 1'b1;
              w_op_next     = r_next_op;
              w_count_next  = '0;
              w_state_next  = OP_WAIT;
`endif
            end else begin
              w_state_next = SHOW;
            end
          end else if (w_expire) begin
            w_state_next = ERROR;
          end
        end
        SHOW: begin
          if (w_op) begin
            w_v1_load_ans = 1'b1;
            w_v2_clear    = 1'b1;
            w_op_next     = i_opcode;
            w_count_next  = '0;
            w_state_next  = OP_WAIT;
          end else if (w_hex) begin
            w_v1_clear   = 1'b1;
            w_v1_shift   = 1'b1;
            w_v2_clear   = 1'b1;
            w_hex_next   = i_hexcode;
            w_count_next = CW'(1);
            w_state_next = ENTER_V1;
          end
        end
        ERROR: begin
          w_state_next = ERROR;
        end
        default: begin
          w_state_next = ENTER_V1;
        end
      endcase
    end
  end

  // Register state, counters, strobes and display outputs.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ENTER_V1;
      r_count       <= '0;
      r_hex_out     <= 4'd0;
      r_alu_op      <= OP_ADD;
      r_disp_sel    <= DISP_V1;
      r_err         <= 1'b0;
      r_v1_shift    <= 1'b0;
      r_v2_shift    <= 1'b0;
      r_v1_clear    <= 1'b0;
      r_v2_clear    <= 1'b0;
      r_v1_load_ans <= 1'b0;
      r_alu_start   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_count       <= w_count_next;
      r_hex_out     <= w_hex_next;
      r_alu_op      <= w_op_next;
      r_disp_sel    <= disp_for_state(w_state_next, r_disp_sel);
      r_err         <= (w_state_next == ERROR);
      r_v1_shift    <= w_v1_shift;
      r_v2_shift    <= w_v2_shift;
      r_v1_clear    <= w_v1_clear;
      r_v2_clear    <= w_v2_clear;
      r_v1_load_ans <= w_v1_load_ans;
      r_alu_start   <= w_alu_start;
    end
  end

`ifdef CALC_CHAIN_EN
  // Remember whether the running operation chains into a stored operator.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_chain   <= 1'b0;
      r_next_op <= OP_ADD;
    end else begin
      r_chain   <= w_chain_next;
      r_next_op <= w_next_op_next;
    end
  end
`endif

  assign o_hex_out     = r_hex_out;
  assign o_v1_shift    = r_v1_shift;
  assign o_v2_shift    = r_v2_shift;
  assign o_v1_clear    = r_v1_clear;
  assign o_v2_clear    = r_v2_clear;
  assign o_v1_load_ans = r_v1_load_ans;
  assign o_alu_op      = r_alu_op;
  assign o_alu_start   = r_alu_start;
  assign o_disp_sel    = r_disp_sel;
  assign o_err         = r_err;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed self-checking bench for calc_sequencer.
// Strobes are compared as one vector {v1Shift, v1Clear, v2Shift, v2Clear, v1LoadAns, aluStart}.
module tb_calc_sequencer;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       newHex = 1'b0;
  logic [3:0] hexCode = 4'd0;
  logic       newOp = 1'b0;
  logic [1:0] opCode = 2'd0;
  logic       eqKey = 1'b0;
  logic       clrKey = 1'b0;
  logic       aluDone = 1'b0;
  logic       aluOvw = 1'b0;
  logic [3:0] hexOut;
  logic       v1Shift, v2Shift, v1Clear, v2Clear, v1LoadAns, aluStart, errOut;
  logic [1:0] aluOp, dispSel;

  int checkCount = 0;
  int failCount  = 0;

  calc_sequencer #(.DIGITS(4), .ARITH_TIMEOUT(32)) dut (
    .i_clock       (clock),
    .i_reset       (resetN),
    .i_newhex      (newHex),
    .i_hexcode     (hexCode),
    .i_newop       (newOp),
    .i_opcode      (opCode),
    .i_eq          (eqKey),
    .i_clr         (clrKey),
    .i_alu_done    (aluDone),
    .i_alu_ovw     (aluOvw),
    .o_hex_out     (hexOut),
    .o_v1_shift    (v1Shift),
    .o_v2_shift    (v2Shift),
    .o_v1_clear    (v1Clear),
    .o_v2_clear    (v2Clear),
    .o_v1_load_ans (v1LoadAns),
    .o_alu_op      (aluOp),
    .o_alu_start   (aluStart),
    .o_disp_sel    (dispSel),
    .o_err         (errOut)
  );

  always #5 clock = ~clock;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {v1Shift, v1Clear, v2Shift, v2Clear, v1LoadAns, aluStart};
  endfunction

  // Drive one cycle of key/ALU inputs, then sample just after the clock edge.
  task automatic applyStimulus(input logic nh, input logic [3:0] hc, input logic no, input logic [1:0] oc,
                               input logic e, input logic c, input logic d, input logic ov);
    @(negedge clock);
    newHex = nh; hexCode = hc; newOp = no; opCode = oc;
    eqKey = e; clrKey = c; aluDone = d; aluOvw = ov;
    @(posedge clock);
    #1;
    newHex = 1'b0; newOp = 1'b0; eqKey = 1'b0; clrKey = 1'b0; aluDone = 1'b0; aluOvw = 1'b0;
  endtask

  task automatic pressHex(input logic [3:0] h);   applyStimulus(1, h, 0, 0, 0, 0, 0, 0); endtask
  task automatic pressOp(input logic [1:0] o);    applyStimulus(0, 0, 1, o, 0, 0, 0, 0); endtask
  task automatic pressEq();                       applyStimulus(0, 0, 0, 0, 1, 0, 0, 0); endtask
  task automatic pressClr();                      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0); endtask
  task automatic pulseDone(input logic ov);       applyStimulus(0, 0, 0, 0, 0, 0, 1, ov); endtask
  task automatic idleCycle();                     applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); endtask

  // Compare the strobe vector, display select and error flag in one go.
  task automatic expectCycle(input string tag, input logic [5:0] s, input logic [1:0] d, input logic e);
    checkOutput({tag, ".strobes"}, 32'(strobes()), 32'(s));
    checkOutput({tag, ".disp"}, 32'(dispSel), 32'(d));
    checkOutput({tag, ".err"}, 32'(errOut), 32'(e));
  endtask

  int shiftCount;

  initial begin
    $display("[TB] calc_sequencer directed test start");
    repeat (2) @(posedge clock);
    #1;
    expectCycle("reset", 6'b000000, 2'd0, 1'b0);
    checkOutput("reset.aluOp", 32'(aluOp), 32'd0);
    checkOutput("reset.hexOut", 32'(hexOut), 32'd0);
    @(negedge clock);
    resetN = 1'b1;

    // 12 + 3 =
    pressHex(4'h1);  expectCycle("d1", 6'b100000, 2'd0, 1'b0); checkOutput("d1.hex", 32'(hexOut), 32'h1);
    pressHex(4'h2);  expectCycle("d2", 6'b100000, 2'd0, 1'b0); checkOutput("d2.hex", 32'(hexOut), 32'h2);
    pressOp(2'd0);   expectCycle("opAdd", 6'b000000, 2'd0, 1'b0); checkOutput("opAdd.aluOp", 32'(aluOp), 32'd0);
    pressHex(4'h3);  expectCycle("v2First", 6'b001100, 2'd1, 1'b0); checkOutput("v2First.hex", 32'(hexOut), 32'h3);
    pressEq();       expectCycle("eqStart", 6'b000001, 2'd1, 1'b0); checkOutput("eqStart.aluOp", 32'(aluOp), 32'd0);
    idleCycle();     expectCycle("startOnce", 6'b000000, 2'd1, 1'b0);
    pulseDone(1'b0); expectCycle("show", 6'b000000, 2'd2, 1'b0);

    // New digit from SHOW restarts V1; then five digits with only four accepted
    pressHex(4'h5);  expectCycle("showHex", 6'b110100, 2'd0, 1'b0);
    pressClr();      expectCycle("clr1", 6'b010100, 2'd0, 1'b0);
    shiftCount = 0;
    for (int i = 0; i < 4; i++) begin
      pressHex(4'(10 + i));
      if (v1Shift) shiftCount++;
    end
    pressHex(4'hE);  expectCycle("fifthDigit", 6'b000000, 2'd0, 1'b0);
    checkOutput("digitLimit.count", 32'(shiftCount), 32'd4);
    checkOutput("digitLimit.hex", 32'(hexOut), 32'hD);

    // Overflow into ERROR; keys other than clr are ignored there
    pressOp(2'd1);   expectCycle("opSub", 6'b000000, 2'd0, 1'b0); checkOutput("opSub.aluOp", 32'(aluOp), 32'd1);
    pressHex(4'h7);  expectCycle("ovfV2", 6'b001100, 2'd1, 1'b0);
    pressEq();       expectCycle("ovfStart", 6'b000001, 2'd1, 1'b0);
    pulseDone(1'b1); expectCycle("ovfErr", 6'b000000, 2'd3, 1'b1);
    pressHex(4'h1);  expectCycle("errHex", 6'b000000, 2'd3, 1'b1); checkOutput("errHex.hex", 32'(hexOut), 32'h7);
    pressOp(2'd2);   expectCycle("errOp", 6'b000000, 2'd3, 1'b1); checkOutput("errOp.aluOp", 32'(aluOp), 32'd1);
    pressEq();       expectCycle("errEq", 6'b000000, 2'd3, 1'b1);
    pressClr();      expectCycle("errClr", 6'b010100, 2'd0, 1'b0);

    // Priority: newop beats newhex, clr beats eq
    applyStimulus(1, 4'h9, 1, 2'd2, 0, 0, 0, 0);
    expectCycle("prioOp", 6'b000000, 2'd0, 1'b0); checkOutput("prioOp.aluOp", 32'(aluOp), 32'd2);
    pressHex(4'h4);  expectCycle("prioV2", 6'b001100, 2'd1, 1'b0); checkOutput("prioV2.hex", 32'(hexOut), 32'h4);
    applyStimulus(0, 4'h0, 0, 2'd0, 1, 1, 0, 0);
    expectCycle("prioClr", 6'b010100, 2'd0, 1'b0);

    // Timeout: no alu_done for 32 EXEC cycles, ERROR on the 33rd
    pressOp(2'd3);   expectCycle("toOp", 6'b000000, 2'd0, 1'b0);
    pressHex(4'h4);  expectCycle("toV2", 6'b001100, 2'd1, 1'b0);
    pressEq();       expectCycle("toStart", 6'b000001, 2'd1, 1'b0); checkOutput("toStart.aluOp", 32'(aluOp), 32'd3);
    repeat (32) idleCycle();
    expectCycle("toCycle32", 6'b000000, 2'd1, 1'b0);
    idleCycle();     expectCycle("toCycle33", 6'b000000, 2'd3, 1'b1);
    pulseDone(1'b0); expectCycle("toLateDone", 6'b000000, 2'd3, 1'b1);
    pressClr();      expectCycle("toClr", 6'b010100, 2'd0, 1'b0);

    // 2 + 3 x : chained operation only when the feature is built
    pressHex(4'h2);  expectCycle("chD1", 6'b100000, 2'd0, 1'b0);
    pressOp(2'd0);   expectCycle("chAdd", 6'b000000, 2'd0, 1'b0);
    pressHex(4'h3);  expectCycle("chD2", 6'b001100, 2'd1, 1'b0);
    pressOp(2'd2);
`ifdef CALC_CHAIN_EN
    expectCycle("chMul", 6'b000001, 2'd1, 1'b0); checkOutput("chMul.aluOp", 32'(aluOp), 32'd0);
    pulseDone(1'b0); expectCycle("chDone", 6'b000110, 2'd0, 1'b0); checkOutput("chDone.aluOp", 32'(aluOp), 32'd2);
    pressHex(4'h4);  expectCycle("chNextV2", 6'b001100, 2'd1, 1'b0);
`else
    expectCycle("chMul", 6'b000000, 2'd1, 1'b0); checkOutput("chMul.aluOp", 32'(aluOp), 32'd0);
    pulseDone(1'b0); expectCycle("chStrayDone", 6'b000000, 2'd1, 1'b0);
    pressEq();       expectCycle("chEq", 6'b000001, 2'd1, 1'b0);
    pulseDone(1'b0); expectCycle("chShow", 6'b000000, 2'd2, 1'b0);
`endif
    pressClr();      expectCycle("chClr", 6'b010100, 2'd0, 1'b0);

    // Reset during EXEC, then a stray alu_done after release
    pressHex(4'h1);
    pressOp(2'd3);
    pressHex(4'h2);
    pressEq();       expectCycle("rstStart", 6'b000001, 2'd1, 1'b0);
    @(negedge clock);
    resetN = 1'b0;
    #1;
    expectCycle("rstMid", 6'b000000, 2'd0, 1'b0);
    checkOutput("rstMid.aluOp", 32'(aluOp), 32'd0);
    checkOutput("rstMid.hex", 32'(hexOut), 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    pulseDone(1'b0); expectCycle("rstDone", 6'b000000, 2'd0, 1'b0);
    pressHex(4'h6);  expectCycle("rstHex", 6'b100000, 2'd0, 1'b0); checkOutput("rstHex.hex", 32'(hexOut), 32'h6);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
